// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: rising edges of scan_clk become ticks that
// step a per-digit slot FSM. Optional leading-zero blanking under SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int ON_TICKS   = 1,
    parameter int GAP_TICKS  = 0
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    scan_clk,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_ON  = 2'd1;
    localparam logic [1:0] S_GAP = 2'd2;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dps;
        logic [NUM_DIGITS-1:0]   blank;
    } disp_buf_t;

    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic             scan_q, scan_qq, tick;
    logic [1:0]       state, state_n;
    logic [IDX_W-1:0] idx, idx_n, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_n;
    disp_buf_t        pend, pend_n, act, act_n, in_buf;
    logic             fd_n;

    logic [NUM_DIGITS-1:0] lz;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;

    assign tick    = scan_q & ~scan_qq;
    assign in_buf  = {digits_in, dp_in, blank_in};
    assign idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        fd_n    = 1'b0;
        pend_n  = load ? in_buf : pend;
        act_n   = act;
        if (!enable) begin
            state_n = S_OFF;
            idx_n   = '0;
            cnt_n   = '0;
        end else if (tick) begin
            case (state)
                S_OFF: begin
                    state_n = S_ON;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        cnt_n = '0;
                        if (GAP_TICKS > 0) state_n = S_GAP;
                        else               idx_n   = idx_nxt;
                        fd_n = (idx == LAST_IDX);
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = S_ON;
                        idx_n   = idx_nxt;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = S_OFF;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
        // A load landing while frame_done is showing still belongs to the new frame,
        // so software reacting to the pulse is not pushed back a whole frame.
        if (fd_n || (frame_done && load)) act_n = pend_n;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign lz[0] = 1'b0;
    for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lz
        assign lz[g] = ~|act_n.digits[4*NUM_DIGITS-1:4*g] & ~act_n.dps[g];
    end
`else
    assign lz = '0;
`endif

    // Outputs are registered from next-state so they line up with the FSM.
    always_comb begin
        lit   = (state_n == S_ON) && !act_n.blank[idx_n] && !lz[idx_n];
        an_n  = '1;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        if (lit) begin
            an_n  = ~(NUM_DIGITS'(1) << idx_n);
            seg_n = decode(act_n.digits[{idx_n, 2'b00} +: 4]);
            dp_n  = ~act_n.dps[idx_n];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            scan_q     <= 1'b0;
            scan_qq    <= 1'b0;
            state      <= S_OFF;
            idx        <= '0;
            cnt        <= '0;
            pend       <= '0;
            act        <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            scan_q     <= scan_clk;
            scan_qq    <= scan_q;
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            pend       <= pend_n;
            act        <= act_n;
            an         <= an_n;
            seg        <= seg_n;
            dp         <= dp_n;
            frame_done <= fd_n;
        end
    end

endmodule
